// File: rtl/led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// led_mode_ctrl
//
// Four-mode display controller that sits between the board's 16 slide
// switches, two push buttons and the 16 LEDs.
//
//   PASS  (0) : LEDs follow the synchronised switches.
//   HOLD  (1) : LEDs show a snapshot of the switches taken on entry.
//               BTNU takes a fresh snapshot.
//   SHIFT (2) : LEDs show a pattern loaded from the switches on entry and
//               rotated left once per tick. An all-zero load becomes 16'h0001.
//               BTNU reloads the pattern and restarts the tick interval.
//   BLINK (3) : LEDs show the live switches, blanked on alternate tick periods.
//
// BTNC steps the mode PASS->HOLD->SHIFT->BLINK->PASS. A BTNC press that lands
// in the same cycle as a BTNU press suppresses the BTNU press.
//
// Optional build macro:
//   LED_DIM_EN : adds a free-running 4-bit PWM gate on the LED output that
//                passes the mode value for DIM_DUTY of every 16 cycles and adds
//                one cycle of output latency. The DIM_DUTY parameter exists
//                only in this build.
//
// Parameters:
//   DEBOUNCE_CYC : consecutive cycles a button must differ from its debounced
//                  state before the change is accepted
//   TICK_CYC     : cycles per SHIFT/BLINK step
//   DIM_DUTY     : PWM on-slots out of 16, 0..16 (LED_DIM_EN only)
//
// Ports:
//   CLK   in   1  system clock
//   RST_N in   1  asynchronous active-low reset
//   SW    in  16  slide switches, asynchronous to CLK
//   BTNC  in   1  mode-step button, asynchronous and bouncy
//   BTNU  in   1  reload/recapture button, asynchronous and bouncy
//   LED   out 16  registered LED drive
//   MODE  out  2  current mode (0 PASS, 1 HOLD, 2 SHIFT, 3 BLINK)
// -----------------------------------------------------------------------------
module led_mode_ctrl #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int TICK_CYC     = 25_000_000
`ifdef LED_DIM_EN
    ,
    parameter int DIM_DUTY     = 4
`endif
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] SW,
    input  logic        BTNC,
    input  logic        BTNU,
    output logic [15:0] LED,
    output logic [1:0]  MODE
);

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_HOLD  = 2'd1,
        MODE_SHIFT = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    // Counter widths leave room for the terminal value itself, so a parameter
    // of 1 still yields a legal one-bit counter.
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int TK_W = $clog2(TICK_CYC + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYC - 1);

    // Button vectors: index 0 is BTNC, index 1 is BTNU.
    localparam int BTN_C = 0;
    localparam int BTN_U = 1;

    // -------------------------------------------------------------------------
    // Input synchronisers and debouncers
    // -------------------------------------------------------------------------
    logic [15:0]           sw_meta_q;
    logic [15:0]           sw_sync_q;
    logic [1:0]            btn_meta_q;
    logic [1:0]            btn_sync_q;
    logic [1:0]            db_state_q;
    logic [1:0]            db_state_d;
    logic [1:0][DB_W-1:0]  db_cnt_q;
    logic [1:0][DB_W-1:0]  db_cnt_d;
    logic [1:0]            press;

    // The debounce counter only runs while the synced button disagrees with
    // the accepted state; any agreeing sample restarts the count, so a glitch
    // shorter than DEBOUNCE_CYC never reaches the terminal value. The press
    // pulse is the cycle in which a 0->1 flip is committed.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // before any branch, otherwise a missed path infers a latch.
        db_state_d = db_state_q;
        db_cnt_d   = '0;
        press      = '0;
        for (int b = 0; b < 2; b++) begin
            if (btn_sync_q[b] != db_state_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    db_state_d[b] = ~db_state_q[b];
                    press[b]      = ~db_state_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // Two flops per input bit: the first may go metastable on an asynchronous
    // edge, the second gives it a full cycle to resolve before use.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            db_state_q <= '0;
            db_cnt_q   <= '0;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop
            // samples the pre-edge value of the others, matching hardware.
            sw_meta_q  <= SW;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= {BTNU, BTNC};
            btn_sync_q <= btn_meta_q;
            db_state_q <= db_state_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Mode FSM, tick generator and pattern datapath
    // -------------------------------------------------------------------------
    mode_e           mode_q;
    mode_e           mode_d;
    logic [15:0]     led_q;
    logic [15:0]     led_d;
    logic [15:0]     hold_q;
    logic [15:0]     hold_d;
    logic [15:0]     pat_q;
    logic [15:0]     pat_d;
    logic            phase_q;
    logic            phase_d;
    logic [TK_W-1:0] tick_cnt_q;
    logic [TK_W-1:0] tick_cnt_d;

    logic btnc_press;
    logic btnu_press;
    logic tick;

    // A rotating pattern of all zeros would be invisible forever, so an empty
    // load is replaced by a single lit LED.
    function automatic logic [15:0] load_pattern(input logic [15:0] sw);
        return (sw == 16'h0000) ? 16'h0001 : sw;
    endfunction

    assign btnc_press = press[BTN_C];
    assign btnu_press = press[BTN_U] & ~press[BTN_C];
    assign tick       = (tick_cnt_q == TK_LAST);

    always_comb begin
        mode_d     = mode_q;
        hold_d     = hold_q;
        pat_d      = pat_q;
        phase_d    = phase_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        if (btnc_press) begin
            // Entering a mode restarts the tick interval so the first step
            // happens a full TICK_CYC after entry.
            mode_d     = mode_e'(mode_q + 2'd1);
            tick_cnt_d = '0;
            case (mode_d)
                MODE_HOLD:  hold_d  = sw_sync_q;
                MODE_SHIFT: pat_d   = load_pattern(sw_sync_q);
                MODE_BLINK: phase_d = 1'b1;
                default:    ;
            endcase
        end else begin
            case (mode_q)
                MODE_HOLD: begin
                    if (btnu_press) begin
                        hold_d = sw_sync_q;
                    end
                end
                MODE_SHIFT: begin
                    if (btnu_press) begin
                        pat_d      = load_pattern(sw_sync_q);
                        tick_cnt_d = '0;
                    end else if (tick) begin
                        pat_d = {pat_q[14:0], pat_q[15]};
                    end
                end
                MODE_BLINK: begin
                    if (tick) begin
                        phase_d = ~phase_q;
                    end
                end
                default: ;
            endcase
        end

        // The LED value is derived from the next-state values so that the
        // new mode and its display are registered on the same edge.
        case (mode_d)
            MODE_PASS:  led_d = sw_sync_q;
            MODE_HOLD:  led_d = hold_d;
            MODE_SHIFT: led_d = pat_d;
            MODE_BLINK: led_d = phase_d ? sw_sync_q : 16'h0000;
            default:    led_d = 16'h0000;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: every register here, datapath included, is reset: they are
            // flops rather than a RAM, and a known value after reset keeps the
            // first HOLD/SHIFT display deterministic.
            mode_q     <= MODE_PASS;
            led_q      <= '0;
            hold_q     <= '0;
            pat_q      <= '0;
            phase_q    <= 1'b1;
            tick_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            led_q      <= led_d;
            hold_q     <= hold_d;
            pat_q      <= pat_d;
            phase_q    <= phase_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output stage
    // -------------------------------------------------------------------------
`ifdef LED_DIM_EN
    logic [3:0]  pwm_q;
    logic [15:0] led_dim_q;

    // Widening both sides to 5 bits lets DIM_DUTY=16 mean "always on".
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm_q     <= '0;
            led_dim_q <= '0;
        end else begin
            pwm_q     <= pwm_q + 4'd1;
            led_dim_q <= ({1'b0, pwm_q} < 5'(DIM_DUTY)) ? led_q : 16'h0000;
        end
    end

    assign LED = led_dim_q;
`else
    assign LED = led_q;
`endif

    assign MODE = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_mode_ctrl
//
// Directed stimulus with hand-computed expectations. The stimulus process
// pushes {cycle, LED, MODE} entries into a queue; an independent monitor pops
// every entry due at the current cycle on the falling clock edge (or on an
// explicit event for the asynchronous-reset check) and compares it with the
// DUT outputs. Runs with DEBOUNCE_CYC=4 and TICK_CYC=8.
//
// Button timing used throughout: a pin driven at the falling edge of cycle N
// is synced by cycle N+2, accepted after four differing cycles (press pulse in
// cycle N+5) and the new MODE/LED are visible in cycle N+6.
// -----------------------------------------------------------------------------
module tb_led_mode_ctrl;

    logic        CLK;
    logic        RST_N;
    logic [15:0] SW;
    logic        BTNC;
    logic        BTNU;
    logic [15:0] LED;
    logic [1:0]  MODE;

    led_mode_ctrl #(
        .DEBOUNCE_CYC (4),
        .TICK_CYC     (8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .SW    (SW),
        .BTNC  (BTNC),
        .BTNU  (BTNU),
        .LED   (LED),
        .MODE  (MODE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] led;
        logic [1:0]  mode;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    event async_ev;

    task automatic push(input int c, input logic [15:0] l, input logic [1:0] m, input string n);
        exp_t e;
        e.cyc  = c;
        e.led  = l;
        e.mode = m;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic check(input exp_t e);
        checks++;
        if (e.cyc != cyc) begin
            failures++;
            $display("FAIL %s: expectation for cycle %0d reached monitor at cycle %0d",
                     e.name, e.cyc, cyc);
        end else if (LED !== e.led || MODE !== e.mode) begin
            failures++;
            $display("FAIL %s: cycle %0d got LED=%h MODE=%0d, expected LED=%h MODE=%0d",
                     e.name, cyc, LED, MODE, e.led, e.mode);
        end
    endtask

    // Monitor: consumes every expectation that has come due.
    exp_t mon_e;
    always begin
        @(negedge CLK or async_ev);
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            check(mon_e);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    // Called at a falling edge; eff is the cycle in which the press takes effect.
    task automatic press_start(input logic c, input logic u, output int eff);
        BTNC = c;
        BTNU = u;
        eff  = cyc + 6;
    endtask

    task automatic press_finish(input int n_high);
        repeat (n_high) @(negedge CLK);
        BTNC = 1'b0;
        BTNU = 1'b0;
        repeat (8) @(negedge CLK);
    endtask

    task automatic finish_run();
        if (exp_q.size() != 0) begin
            checks   += exp_q.size();
            failures += exp_q.size();
            $display("FAIL pending: %0d expectations never compared, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    int t;
    int eff;
    int s;
    int b;

    initial begin
        RST_N = 1'b0;
        SW    = 16'h0000;
        BTNC  = 1'b0;
        BTNU  = 1'b0;

`ifdef LED_DIM_EN
        // PWM gate: with SW=FFFF held through reset, the gated LED is on only
        // when the pre-edge PWM count is below 4.
        SW = 16'hFFFF;
        @(negedge CLK);
        push(cyc + 1, 16'h0000, 2'd0, "dim_reset");
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        t = cyc;
        for (int j = 17; j <= 32; j++) begin
            push(t + j, (((j - 1) % 16) < 4) ? 16'hFFFF : 16'h0000, 2'd0, "dim_gate");
        end
        wait_until(t + 33);
        finish_run();
`else
        // 1. Reset state; switches moving during reset must not reach LED.
        @(negedge CLK);
        push(cyc + 1, 16'h0000, 2'd0, "reset_state");
        SW = 16'hFFFF;
        push(cyc + 3, 16'h0000, 2'd0, "reset_sw_ignored");
        repeat (4) @(negedge CLK);
        RST_N = 1'b1;
        SW    = 16'h0000;

        // PASS latency is exactly three cycles.
        @(negedge CLK);
        SW = 16'hA5C3;
        t  = cyc;
        push(t + 2, 16'h0000, 2'd0, "pass_before_latency");
        push(t + 3, 16'hA5C3, 2'd0, "pass_latency3");
        wait_until(t + 4);
        SW = 16'h1234;
        t  = cyc;
        push(t + 3, 16'h1234, 2'd0, "pass_1234");
        wait_until(t + 4);

        // 2. Debounce: three cycles high is one short of acceptance.
        BTNC = 1'b1;
        t    = cyc;
        push(t + 6,  16'h1234, 2'd0, "db_short_6");
        push(t + 12, 16'h1234, 2'd0, "db_short_12");
        repeat (3) @(negedge CLK);
        BTNC = 1'b0;
        wait_until(t + 13);

        // Ten cycles high: exactly one step into HOLD with SW=1234 captured.
        press_start(1'b1, 1'b0, eff);
        push(eff - 1, 16'h1234, 2'd0, "db_long_pre");
        push(eff,     16'h1234, 2'd1, "hold_entry");
        press_finish(10);

        // Five single-cycle glitches produce no further step.
        t = cyc;
        push(t + 21, 16'h1234, 2'd1, "db_glitch_a");
        for (int g = 0; g < 5; g++) begin
            BTNC = 1'b1;
            @(negedge CLK);
            BTNC = 1'b0;
            repeat (3) @(negedge CLK);
        end
        push(t + 25, 16'h1234, 2'd1, "db_glitch_b");
        wait_until(t + 26);

        // 3. HOLD ignores SW; BTNU recaptures.
        SW = 16'hFFFF;
        t  = cyc;
        push(t + 5, 16'h1234, 2'd1, "hold_ignore_sw");
        wait_until(t + 6);
        press_start(1'b0, 1'b1, eff);
        push(eff - 1, 16'h1234, 2'd1, "recapture_pre");
        push(eff,     16'hFFFF, 2'd1, "hold_recapture");
        press_finish(6);

        // 4. SHIFT: load 8001, rotate on each tick.
        SW = 16'h8001;
        wait_until(cyc + 4);
        press_start(1'b1, 1'b0, s);
        push(s - 1,  16'hFFFF, 2'd1, "shift_pre");
        push(s,      16'h8001, 2'd2, "shift_entry");
        push(s + 7,  16'h8001, 2'd2, "shift_before_tick1");
        push(s + 8,  16'h0003, 2'd2, "shift_tick1");
        push(s + 15, 16'h0003, 2'd2, "shift_before_tick2");
        push(s + 16, 16'h0006, 2'd2, "shift_tick2");
        press_finish(6);

        // BTNU reload with SW=0 loads 0001 and restarts the tick interval.
        wait_until(s + 17);
        SW = 16'h0000;
        wait_until(s + 21);
        press_start(1'b0, 1'b1, eff);
        push(eff - 1, 16'h000C, 2'd2, "reload_pre");
        push(eff,     16'h0001, 2'd2, "reload_zero");
        push(eff + 7, 16'h0001, 2'd2, "reload_tick_restart");
        push(eff + 8, 16'h0002, 2'd2, "reload_tick");
        press_finish(6);

        // Coincident BTNC+BTNU: mode advances to BLINK.
        SW = 16'h00FF;
        wait_until(cyc + 4);
        press_start(1'b1, 1'b1, b);
        push(b - 1,  16'h0004, 2'd2, "coincide_pre");
        push(b,      16'h00FF, 2'd3, "blink_entry");
        // 5. BLINK: 8 cycles on, 8 off.
        push(b + 7,  16'h00FF, 2'd3, "blink_on_last");
        push(b + 8,  16'h0000, 2'd3, "blink_off");
        push(b + 15, 16'h0000, 2'd3, "blink_off_last");
        push(b + 16, 16'h00FF, 2'd3, "blink_on_again");
        press_finish(6);
        wait_until(b + 17);
        SW = 16'h0F0F;
        push(b + 20, 16'h0F0F, 2'd3, "blink_live_sw");
        wait_until(b + 26);

        // Wrap BLINK -> PASS.
        press_start(1'b1, 1'b0, eff);
        push(eff - 1, 16'h0000, 2'd3, "wrap_pre");
        push(eff,     16'h0F0F, 2'd0, "wrap_pass");
        press_finish(6);

        // Re-enter SHIFT with SW=0: zero rule on entry.
        SW = 16'h0000;
        wait_until(cyc + 4);
        press_start(1'b1, 1'b0, eff);
        push(eff - 1, 16'h0000, 2'd0, "pass_zero");
        push(eff,     16'h0000, 2'd1, "hold_zero");
        press_finish(6);
        press_start(1'b1, 1'b0, eff);
        push(eff - 1, 16'h0000, 2'd1, "hold_zero_pre");
        push(eff,     16'h0001, 2'd2, "shift_zero_entry");
        push(eff + 8, 16'h0002, 2'd2, "shift_zero_tick");
        press_finish(6);

        // 6. Asynchronous reset between ticks: outputs clear with no edge.
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        push(cyc, 16'h0000, 2'd0, "async_reset");
        ->async_ev;
        @(negedge CLK);
        push(cyc + 1, 16'h0000, 2'd0, "reset_held");
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        wait_until(cyc + 2);
        finish_run();
`endif
    end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
- Controller that sequences the board's 16 slide switches onto the 16 LEDs.
- Replaces the direct switch-to-LED wire with a four-mode display controller: pass-through, hold, rotate, blink.
- Mode is stepped by a debounced centre button; a second debounced button reloads or recaptures the pattern.
- Sits at top level between the board switch/button pins and the LED pins.

Parameters:
- DEBOUNCE_CYC, 1_000_000, consecutive stable cycles required to accept a button change (10 ms at 100 MHz)
- TICK_CYC, 25_000_000, cycles per pattern step in SHIFT/BLINK (4 Hz at 100 MHz)
- DIM_DUTY, 4, PWM on-slots out of 16 when LED_DIM_EN is defined (0..16)

Ports:
- CLK  input  1  system clock, 100 MHz
- RST_N  input  1  asynchronous active-low reset
- SW  input  16  slide switches, asynchronous to CLK
- BTNC  input  1  mode-step button, asynchronous, bouncy
- BTNU  input  1  reload button, asynchronous, bouncy
- LED  output  16  registered LED drive
- MODE  output  2  current mode: 0 PASS, 1 HOLD, 2 SHIFT, 3 BLINK

Interface: one clock, CLK; reset RST_N is asynchronous, active-low.

Behaviour:
- Reset (RST_N low, takes effect immediately, asynchronous):
  - LED=0, MODE=0 (PASS).
  - All sync flops, debounced states, debounce counters and tick counter = 0; blink phase = 1.
- Synchronisers:
  - SW, BTNC and BTNU each pass through a 2-flop synchroniser.
- Debounce (per button):
  - Counter clears whenever the synced input equals the debounced state; otherwise it increments.
  - The debounced state flips on the cycle in which the input has differed for DEBOUNCE_CYC consecutive cycles.
  - A rising edge of the debounced state produces a one-cycle press pulse.
  - A button held through reset release yields exactly one press after sync + DEBOUNCE_CYC cycles (intended).
- Mode FSM:
  - On each BTNC press: PASS->HOLD->SHIFT->BLINK->PASS.
  - If BTNC and BTNU press pulses coincide, the BTNC press wins and BTNU is dropped.
- Tick:
  - Counter runs 0..TICK_CYC-1; tick pulse fires when count = TICK_CYC-1, then wraps to 0.
  - Counter clears on every mode change, so the first tick occurs TICK_CYC cycles after entry.
- PASS: LED <= synced SW. Latency from SW pin change to LED is 3 cycles.
- HOLD:
  - On entry, hold register <= synced SW, and LED shows the hold register; SW is ignored afterwards.
  - BTNU press recaptures synced SW into the hold register.
- SHIFT:
  - On entry, pattern register <= synced SW; if synced SW = 0, it loads 16'h0001 instead.
  - On each tick, rotate left by 1 (bit15 -> bit0).
  - BTNU press reloads the pattern using the same zero rule and clears the tick counter.
  - LED = pattern register.
- BLINK:
  - Phase = 1 on entry and toggles on each tick.
  - LED = synced SW when phase = 1, 0 when phase = 0. SW changes are tracked live.
  - BTNU has no effect.
- MODE changes in the cycle after the press pulse. The LED value for the new mode appears in that same cycle (registered together with MODE).

Optional Feature:
- Macro LED_DIM_EN.
- Defined:
  - A free-running 4-bit PWM counter (reset 0) gates the output: final LED = mode LED value when the counter < DIM_DUTY, else 0.
  - DIM_DUTY=16 means always on; DIM_DUTY=0 means always off.
  - The gate is registered, adding 1 cycle of latency.
- Not defined: no PWM counter; LED is driven directly from the mode logic with the latencies above.

Test Plan (DEBOUNCE_CYC=4, TICK_CYC=8, LED_DIM_EN undefined unless stated):
1. Reset: assert RST_N=0 -> LED=0000, MODE=0. Release, then SW=16'hA5C3 -> LED=A5C3 exactly 3 cycles after the SW change.
2. Debounce: BTNC high 3 cycles then low -> MODE stays 0. BTNC high 10 cycles -> MODE=1 exactly once; 5 glitches of 1 cycle each -> no further change.
3. HOLD: SW=1234, BTNC press -> MODE=1, LED=1234. SW=FFFF -> LED stays 1234. BTNU press -> LED=FFFF.
4. SHIFT: SW=8001, enter SHIFT -> LED=8001, then 0003 after 8 cycles, then 0006 after 16. Re-enter with SW=0000 -> LED=0001. BTNC and BTNU pressed in the same cycle -> mode advances, no reload.
5. BLINK/wrap: SW=00FF -> LED=00FF for 8 cycles, 0000 for 8 cycles, repeating. BTNC press -> MODE=0, LED=SW.
6. Reset mid-operation: drop RST_N during SHIFT between ticks -> LED=0 and MODE=0 with no clock edge. With LED_DIM_EN and DIM_DUTY=4, PASS with SW=FFFF -> LED=FFFF for 4 of every 16 cycles.
